wino_input_streamer: RTL and testbench

WINO_INPUT_STREAMER -- requirements
Module: wino_input_streamer

---
 rtl/wino_input_streamer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_wino_input_streamer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wino_input_streamer.sv
// wino_input_streamer
//   Streams 6x6 input tiles from a tile memory and applies the Winograd
//   F(4x4,3x3) input transform V = B^T d B to LANES tiles in parallel.
//   A job covers N = block_width_i*block_height_i tiles of channel input_id_i,
//   starting at tile address base = N*input_id_i, in groups of LANES tiles.
//
//   Optional feature: define WINO_BYPASS_EN to build the raw-tile path. When it
//   is built, bypass_i sampled with start_i makes every tile of that job pass
//   through untransformed, sign-extended to OUT_W. Without the macro bypass_i
//   is ignored.
//
// Ports
//   clk, reset                       clock, asynchronous active-high reset
//   block_width_i, block_height_i    tile grid dimensions
//   input_id_i                       channel index
//   start_i, bypass_i                job start pulse, raw-tile select
//   busy_o, done_o                   job in progress, one-cycle job-end pulse
//   mem_req_o, mem_addr_o            fetch request, per-lane tile address
//   mem_valid_i, mem_data_i          fetch response, per-lane 6x6 tile
//   tile_valid_o, tile_ready_i       output handshake
//   lane_mask_o, tile_o              active lanes, per-lane 6x6 result
//
// Element packing: lane l, row r, column c sits at index l*36 + r*6 + c.
//
// state  | meaning
// IDLE   | waiting for start_i
// FETCH  | mem_req_o held until the first mem_valid_i
// XFORM  | row pass registered, column pass being computed
// OUT    | tile_valid_o high until tile_ready_i
module wino_input_streamer #(
  parameter int DATA_W = 16,
  parameter int LANES  = 2,
  parameter int ADDR_W = 8,
  localparam int OUT_W = DATA_W + 7
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [7:0]                       block_width_i,
  input  logic [7:0]                       block_height_i,
  input  logic [3:0]                       input_id_i,
  input  logic                             start_i,
  input  logic                             bypass_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             mem_req_o,
  output logic [LANES*ADDR_W-1:0]          mem_addr_o,
  input  logic                             mem_valid_i,
  input  logic signed [LANES*36*DATA_W-1:0] mem_data_i,
  output logic                             tile_valid_o,
  input  logic                             tile_ready_i,
  output logic [LANES-1:0]                 lane_mask_o,
  output logic signed [LANES*36*OUT_W-1:0] tile_o
);

  localparam int NE = 36;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_XFORM, S_OUT} state_t;

  state_t                     state_q;
  logic [15:0]                n_q;
  logic [19:0]                base_q;
  logic [15:0]                g_q;
  logic                       mem_req_q;
  logic [LANES*ADDR_W-1:0]    addr_q;
  logic [LANES-1:0]           mask_q;
  logic [LANES*NE*OUT_W-1:0]  row_q;
  logic [LANES*NE*OUT_W-1:0]  tile_q;
  logic                       tile_valid_q;
  logic                       zero_done_q;

  logic [15:0]                n_in;
  logic [19:0]                base_in;
  logic [15:0]                g_sel;
  logic [15:0]                n_sel;
  logic [19:0]                base_sel;
  logic [31:0]                idx;
  logic [31:0]                next_start;
  logic                       more;
  logic [LANES*ADDR_W-1:0]    addr_d;
  logic [LANES-1:0]           mask_d;
  logic [LANES*NE*OUT_W-1:0]  row_d;
  logic [LANES*NE*OUT_W-1:0]  col_d;
  logic [6*OUT_W-1:0]         row_vec;
  logic [6*OUT_W-1:0]         row_res;
  logic [6*OUT_W-1:0]         col_vec;
  logic [6*OUT_W-1:0]         col_res;

`ifdef WINO_BYPASS_EN
  logic                       bypass_q;
`else
  logic                       unused_bypass;
  assign unused_bypass = bypass_i;
`endif

  function automatic logic [OUT_W-1:0] sext(input logic [DATA_W-1:0] v);
    return {{(OUT_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  // One B^T pass over a 6-vector, shifts and adds only. Row coefficient
  // magnitudes sum to at most 10, so two passes stay inside DATA_W+7 bits.
  function automatic logic [6*OUT_W-1:0] bt6(input logic [6*OUT_W-1:0] x);
    logic signed [OUT_W-1:0] x0, x1, x2, x3, x4, x5;
    logic signed [OUT_W-1:0] r0, r1, r2, r3, r4, r5;
    x0 = x[0*OUT_W +: OUT_W];
    x1 = x[1*OUT_W +: OUT_W];
    x2 = x[2*OUT_W +: OUT_W];
    x3 = x[3*OUT_W +: OUT_W];
    x4 = x[4*OUT_W +: OUT_W];
    x5 = x[5*OUT_W +: OUT_W];
    r0 = (x0 <<< 2) - (x2 <<< 2) - x2 + x4;
    r1 = x3 + x4 - (x1 <<< 2) - (x2 <<< 2);
    r2 = (x1 <<< 2) - (x2 <<< 2) - x3 + x4;
    r3 = (x3 <<< 1) + x4 - (x1 <<< 1) - x2;
    r4 = (x1 <<< 1) - x2 - (x3 <<< 1) + x4;
    r5 = (x1 <<< 2) - (x3 <<< 2) - x3 + x5;
    return {r5, r4, r3, r2, r1, r0};
  endfunction

  assign n_in    = {8'd0, block_width_i} * {8'd0, block_height_i};
  assign base_in = {4'd0, n_in} * {16'd0, input_id_i};

  // From IDLE the first group is built from the live inputs; from OUT it is
  // the group after the one just transferred.
  assign g_sel    = (state_q == S_IDLE) ? 16'd0 : g_q + 16'd1;
  assign n_sel    = (state_q == S_IDLE) ? n_in : n_q;
  assign base_sel = (state_q == S_IDLE) ? base_in : base_q;

  assign next_start = ({16'd0, g_q} + 32'd1) * 32'(LANES);
  assign more       = next_start < {16'd0, n_q};

  always_comb begin
    addr_d = '0;
    mask_d = '0;
    idx    = '0;
    for (int l = 0; l < LANES; l++) begin
      idx = {16'd0, g_sel} * 32'(LANES) + 32'(l);
      if (idx < {16'd0, n_sel}) begin
        mask_d[l] = 1'b1;
        addr_d[l*ADDR_W +: ADDR_W] = ADDR_W'({12'd0, base_sel} + idx);
      end
    end
  end

  // Row pass: T = B^T d, one column of d at a time.
  always_comb begin
    row_d   = '0;
    row_vec = '0;
    row_res = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int j = 0; j < 6; j++) begin
        for (int k = 0; k < 6; k++)
          row_vec[k*OUT_W +: OUT_W] = sext(mem_data_i[(l*NE + k*6 + j)*DATA_W +: DATA_W]);
`ifdef WINO_BYPASS_EN
        row_res = bypass_q ? row_vec : bt6(row_vec);
`else
        row_res = bt6(row_vec);
`endif
        for (int i = 0; i < 6; i++)
          row_d[(l*NE + i*6 + j)*OUT_W +: OUT_W] = row_res[i*OUT_W +: OUT_W];
      end
    end
  end

  // Column pass: V = T B, one row of T at a time; inactive lanes forced to 0.
  always_comb begin
    col_d   = '0;
    col_vec = '0;
    col_res = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int i = 0; i < 6; i++) begin
        for (int k = 0; k < 6; k++)
          col_vec[k*OUT_W +: OUT_W] = row_q[(l*NE + i*6 + k)*OUT_W +: OUT_W];
`ifdef WINO_BYPASS_EN
        col_res = bypass_q ? col_vec : bt6(col_vec);
`else
        col_res = bt6(col_vec);
`endif
        if (mask_q[l]) begin
          for (int j = 0; j < 6; j++)
            col_d[(l*NE + i*6 + j)*OUT_W +: OUT_W] = col_res[j*OUT_W +: OUT_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      base_q       <= '0;
      g_q          <= '0;
      mem_req_q    <= 1'b0;
      addr_q       <= '0;
      mask_q       <= '0;
      row_q        <= '0;
      tile_q       <= '0;
      tile_valid_q <= 1'b0;
      zero_done_q  <= 1'b0;
`ifdef WINO_BYPASS_EN
      bypass_q     <= 1'b0;
`endif
    end else begin
      zero_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            n_q    <= n_in;
            base_q <= base_in;
            g_q    <= '0;
`ifdef WINO_BYPASS_EN
            bypass_q <= bypass_i;
`endif
            if (n_in == 16'd0) begin
              zero_done_q <= 1'b1;
            end else begin
              state_q   <= S_FETCH;
              mem_req_q <= 1'b1;
              addr_q    <= addr_d;
              mask_q    <= mask_d;
            end
          end
        end
        S_FETCH: begin
          if (mem_valid_i) begin
            row_q     <= row_d;
            mem_req_q <= 1'b0;
            state_q   <= S_XFORM;
          end
        end
        S_XFORM: begin
          tile_q       <= col_d;
          tile_valid_q <= 1'b1;
          state_q      <= S_OUT;
        end
        S_OUT: begin
          if (tile_ready_i) begin
            tile_valid_q <= 1'b0;
            g_q          <= g_q + 16'd1;
            if (more) begin
              state_q   <= S_FETCH;
              mem_req_q <= 1'b1;
              addr_q    <= addr_d;
              mask_q    <= mask_d;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  // The last transfer ends the job in the same cycle it completes.
  assign done_o       = zero_done_q | (tile_valid_q & tile_ready_i & ~more);
  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = addr_q;
  assign tile_valid_o = tile_valid_q;
  assign lane_mask_o  = mask_q;
  assign tile_o       = tile_q;

endmodule

// File: tb/tb_wino_input_streamer.sv
module tb_wino_input_streamer;
  localparam int DATA_W = 16;
  localparam int LANES  = 2;
  localparam int ADDR_W = 8;
  localparam int OUT_W  = DATA_W + 7;
  localparam int NE     = 36;

  logic                          clk = 1'b0;
  logic                          reset;
  logic [7:0]                    block_width_i;
  logic [7:0]                    block_height_i;
  logic [3:0]                    input_id_i;
  logic                          start_i;
  logic                          bypass_i;
  logic                          busy_o;
  logic                          done_o;
  logic                          mem_req_o;
  logic [LANES*ADDR_W-1:0]       mem_addr_o;
  logic                          mem_valid_i;
  logic [LANES*NE*DATA_W-1:0]    mem_data_i;
  logic                          tile_valid_o;
  logic                          tile_ready_i;
  logic [LANES-1:0]              lane_mask_o;
  logic [LANES*NE*OUT_W-1:0]     tile_o;

  wino_input_streamer #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .block_width_i(block_width_i), .block_height_i(block_height_i),
    .input_id_i(input_id_i), .start_i(start_i), .bypass_i(bypass_i),
    .busy_o(busy_o), .done_o(done_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
    .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
    .lane_mask_o(lane_mask_o), .tile_o(tile_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int     bt   [6][6];
  int     dmat [LANES][6][6];
  longint vexp [LANES][6][6];
  bit     mask_exp [LANES];

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic longint tile_elem(input int l, input int i, input int j);
    logic signed [OUT_W-1:0] e;
    e = tile_o[(l*NE + i*6 + j)*OUT_W +: OUT_W];
    return longint'(e);
  endfunction

  task automatic fill_data(input int mode);
    for (int l = 0; l < LANES; l++)
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++) begin
          int v;
          case (mode)
            0: v = int'($urandom_range(0, (1 << DATA_W) - 1)) - (1 << (DATA_W - 1));
            1: v = (l % 2 == 0) ? 1 : ((i == 0 && j == 0) ? 100 : 0);
            2: v = -(1 << (DATA_W - 1));
            3: v = (1 << (DATA_W - 1)) - 1;
            default: v = int'($urandom_range(0, 15)) - 8;
          endcase
          dmat[l][i][j] = v;
          mem_data_i[(l*NE + i*6 + j)*DATA_W +: DATA_W] = DATA_W'(v);
        end
  endtask

  // Reference: plain matrix arithmetic V = B^T d B over integers.
  task automatic compute_exp(input int n, input int g, input bit bp);
    for (int l = 0; l < LANES; l++) begin
      mask_exp[l] = (g*LANES + l) < n;
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++) begin
          longint acc = 0;
          if (mask_exp[l]) begin
            if (bp) acc = dmat[l][i][j];
            else
              for (int k = 0; k < 6; k++)
                for (int m = 0; m < 6; m++)
                  acc += longint'(bt[i][k]) * dmat[l][k][m] * bt[j][m];
          end
          vexp[l][i][j] = acc;
        end
    end
  endtask

  task automatic check_tile(input string tag);
    for (int l = 0; l < LANES; l++) begin
      chk($sformatf("%s_mask%0d", tag, l), longint'(lane_mask_o[l]), longint'(mask_exp[l]));
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++)
          chk($sformatf("%s_l%0d_v%0d%0d", tag, l, i, j), tile_elem(l, i, j), vexp[l][i][j]);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, longint'(busy_o), 0);
    chk({tag, "_done"}, longint'(done_o), 0);
    chk({tag, "_req"}, longint'(mem_req_o), 0);
    chk({tag, "_addr"}, longint'(mem_addr_o), 0);
    chk({tag, "_tvalid"}, longint'(tile_valid_o), 0);
    chk({tag, "_mask"}, longint'(lane_mask_o), 0);
    chk({tag, "_tile"}, longint'(|tile_o), 0);
  endtask

  task automatic run_job(input int w, input int h, input int id, input bit bp,
                         input int mode, input int stall);
    int  n, base, groups, lat, s;
    bit  bp_eff;
`ifdef WINO_BYPASS_EN
    bp_eff = bp;
`else
    bp_eff = 1'b0;
`endif
    n    = w * h;
    base = n * id;
    block_width_i  = 8'(w);
    block_height_i = 8'(h);
    input_id_i     = 4'(id);
    bypass_i       = bp;
    start_i        = 1'b1;
    tick;
    start_i = 1'b0;
    if (n == 0) begin
      chk("zero_done", longint'(done_o), 1);
      chk("zero_req", longint'(mem_req_o), 0);
      chk("zero_busy", longint'(busy_o), 0);
      tick;
      chk("zero_done_end", longint'(done_o), 0);
      return;
    end
    chk("start_busy", longint'(busy_o), 1);
    groups = (n + LANES - 1) / LANES;
    for (int g = 0; g < groups; g++) begin
      chk("fetch_req", longint'(mem_req_o), 1);
      for (int l = 0; l < LANES; l++) begin
        int ea;
        ea = ((g*LANES + l) < n) ? ((base + g*LANES + l) % (1 << ADDR_W)) : 0;
        chk($sformatf("addr_g%0d_l%0d", g, l), longint'(mem_addr_o[l*ADDR_W +: ADDR_W]), ea);
      end
      lat = int'($urandom_range(0, 3));
      repeat (lat) begin
        tick;
        chk("req_hold", longint'(mem_req_o), 1);
      end
      fill_data(mode);
      mem_valid_i = 1'b1;
      tick;
      chk("req_drop", longint'(mem_req_o), 0);
      chk("tvalid_early", longint'(tile_valid_o), 0);
      chk("done_early", longint'(done_o), 0);
      // Stray valid, data and start while busy must all be ignored.
      if ($urandom_range(0, 1) == 1) begin
        mem_valid_i    = 1'b1;
        mem_data_i     = {LANES*NE{$urandom_range(0, 255)}} ^ mem_data_i;
        start_i        = 1'b1;
        block_width_i  = 8'($urandom_range(1, 9));
      end else begin
        mem_valid_i = 1'b0;
      end
      tick;
      mem_valid_i = 1'b0;
      start_i     = 1'b0;
      compute_exp(n, g, bp_eff);
      chk("tvalid", longint'(tile_valid_o), 1);
      check_tile("tile");
      if (mode == 1 && !bp_eff) begin
        if (mask_exp[1]) chk("v00_id100", tile_elem(1, 0, 0), 1600);
        if (mask_exp[0]) chk("v55_ones", tile_elem(0, 5, 5), 0);
      end
      s = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      repeat (s) begin
        tile_ready_i = 1'b0;
        tick;
        chk("stall_tvalid", longint'(tile_valid_o), 1);
        chk("stall_req", longint'(mem_req_o), 0);
        chk("stall_done", longint'(done_o), 0);
        check_tile("stall");
      end
      tile_ready_i = 1'b1;
      #1;
      chk($sformatf("xfer_done_g%0d", g), longint'(done_o), (g == groups - 1) ? 1 : 0);
      tick;
      tile_ready_i = 1'b0;
    end
    chk("end_busy", longint'(busy_o), 0);
    chk("end_done", longint'(done_o), 0);
    chk("end_req", longint'(mem_req_o), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bt = '{'{4, 0, -5, 0, 1, 0}, '{0, -4, -4, 1, 1, 0}, '{0, 4, -4, -1, 1, 0},
           '{0, -2, -1, 2, 1, 0}, '{0, 2, -1, -2, 1, 0}, '{0, 4, 0, -5, 0, 1}};
    reset          = 1'b1;
    block_width_i  = '0;
    block_height_i = '0;
    input_id_i     = '0;
    start_i        = 1'b0;
    bypass_i       = 1'b0;
    mem_valid_i    = 1'b0;
    mem_data_i     = '0;
    tile_ready_i   = 1'b0;
    repeat (2) tick;
    check_idle_zero("rst");
    reset = 1'b0;
    tick;
    check_idle_zero("post_rst");

    run_job(2, 2, 1, 1'b0, 1, 0);
    run_job(3, 1, 0, 1'b1, 0, 5);
    run_job(1, 1, 2, 1'b0, 2, -1);
    run_job(2, 3, 5, 1'b0, 3, 2);
    run_job(0, 5, 3, 1'b0, 0, 0);
    run_job(4, 0, 3, 1'b1, 0, 0);

    // Reset while the job sits in XFORM.
    block_width_i  = 8'd2;
    block_height_i = 8'd1;
    input_id_i     = 4'd3;
    start_i        = 1'b1;
    tick;
    start_i = 1'b0;
    fill_data(0);
    mem_valid_i = 1'b1;
    tick;
    mem_valid_i = 1'b0;
    reset = 1'b1;
    #1;
    check_idle_zero("rst_xform");
    tick;
    reset = 1'b0;
    repeat (3) begin
      tick;
      check_idle_zero("after_rst");
    end

    run_job(2, 2, 1, 1'b0, 0, -1);
    run_job(20, 3, 15, 1'b0, 0, -1);
    run_job(1, 1, 0, 1'b0, 2, 1);
    repeat (15)
      run_job(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 4)), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
